// File: rtl/ysyx_2022040010_uncache_axi_if.sv
// AXI4 bus bundle between the uncached-access engine (master) and the interconnect (slave).
// Only single-beat transfers are issued over it, but the full channel signal set is present.
interface ysyx_2022040010_uncache_axi_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
);
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arsize;
    logic [7:0]          arlen;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;

    logic [DATA_W-1:0]   rdata_axi;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awsize;
    logic [7:0]          awlen;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;

    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output araddr, arsize, arlen, arburst, arvalid,
        input  arready,
        input  rdata_axi, rresp, rlast, rvalid,
        output rready,
        output awaddr, awsize, awlen, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        input  araddr, arsize, arlen, arburst, arvalid,
        output arready,
        output rdata_axi, rresp, rlast, rvalid,
        input  rready,
        input  awaddr, awsize, awlen, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/ysyx_2022040010_uncache_axi.sv
// Uncached load/store engine: turns one MEM-stage request into a single-beat AXI4 transfer
// and signals completion with a one-cycle refresh pulse carrying the read data.
module ysyx_2022040010_uncache_axi #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                req_valid,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [2:0]          req_size,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,

    output logic                refresh,
    output logic [DATA_W-1:0]   rdata,
    output logic                resp_err,
    output logic                busy,

    ysyx_2022040010_uncache_axi_if.master axi
);
    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StAr      = 3'd1;
    localparam logic [2:0] StR       = 3'd2;
    localparam logic [2:0] StAwW     = 3'd3;
    localparam logic [2:0] StB       = 3'd4;
    localparam logic [2:0] StDone    = 3'd5;
    localparam logic [2:0] StWaitLow = 3'd6;

    logic [2:0]          state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [2:0]          size_q, size_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
    logic                arvalid_q, arvalid_d;
    logic                rready_q, rready_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic                bready_q, bready_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                resp_err_q, resp_err_d;

    logic aw_hs, w_hs;
    assign aw_hs = awvalid_q & axi.awready;
    assign w_hs  = wvalid_q & axi.wready;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        size_d     = size_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        arvalid_d  = arvalid_q;
        rready_d   = rready_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        bready_d   = bready_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        rdata_d    = rdata_q;
        resp_err_d = resp_err_q;

        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    size_d  = req_size;
                    wdata_d = req_wdata;
                    wstrb_d = req_wstrb;
                    if (req_we) begin
                        state_d   = StAwW;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                    end else begin
                        state_d   = StAr;
                        arvalid_d = 1'b1;
                    end
                end
            end
            StAr: begin
                if (arvalid_q && axi.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = StR;
                end
            end
            StR: begin
                if (axi.rvalid) begin
                    rdata_d    = axi.rdata_axi;
                    resp_err_d = axi.rresp[1];
                    rready_d   = 1'b0;
                    state_d    = StDone;
                end
            end
            StAwW: begin
                // Address and data channels complete independently, in any order.
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    bready_d = 1'b1;
                    state_d  = StB;
                end
            end
            StB: begin
                if (axi.bvalid) begin
                    resp_err_d = axi.bresp[1];
                    bready_d   = 1'b0;
                    state_d    = StDone;
                end
            end
            StDone: begin
                state_d = StWaitLow;
            end
            StWaitLow: begin
                // Requester still holds the same access until it sees the stall release.
                if (!req_valid) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            size_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            rdata_q    <= '0;
            resp_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            arvalid_q  <= arvalid_d;
            rready_q   <= rready_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            bready_q   <= bready_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            rdata_q    <= rdata_d;
            resp_err_q <= resp_err_d;
        end
    end

    assign refresh  = (state_q == StDone);
    assign busy     = (state_q != StIdle);
    assign rdata    = rdata_q;
    assign resp_err = resp_err_q;

    assign axi.araddr  = addr_q;
    assign axi.arsize  = size_q;
    assign axi.arlen   = 8'd0;
    assign axi.arburst = 2'b01;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;

    assign axi.awaddr  = addr_q;
    assign axi.awsize  = size_q;
    assign axi.awlen   = 8'd0;
    assign axi.awburst = 2'b01;
    assign axi.awvalid = awvalid_q;

    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.wlast   = 1'b1;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = bready_q;

    logic unused_resp;
    assign unused_resp = ^{axi.rlast, axi.rresp[0], axi.bresp[0]};
endmodule

// File: tb/tb_ysyx_2022040010_uncache_axi.sv
// Randomised bench for the uncached AXI engine: a timing/data model derived from the access
// rules (latency formulas, last-read-data register) is compared against the DUT every cycle.
module tb_ysyx_2022040010_uncache_axi;
    localparam int unsigned AW = 64;
    localparam int unsigned DW = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          req_valid;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [2:0]    req_size;
    logic [DW-1:0] req_wdata;
    logic [7:0]    req_wstrb;
    logic          refresh;
    logic [DW-1:0] rdata;
    logic          resp_err;
    logic          busy;

    ysyx_2022040010_uncache_axi_if #(.ADDR_W(AW), .DATA_W(DW)) axi ();

    ysyx_2022040010_uncache_axi #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_size  (req_size),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .refresh   (refresh),
        .rdata     (rdata),
        .resp_err  (resp_err),
        .busy      (busy),
        .axi       (axi)
    );

    int n_checks = 0;
    int n_fail   = 0;
    // Model state: the read data the DUT must be holding (only loads and reset change it).
    logic [DW-1:0] exp_rdata = '0;

    task automatic slave_idle();
        axi.arready   = 1'b0;
        axi.rvalid    = 1'b0;
        axi.rdata_axi = '0;
        axi.rresp     = 2'b00;
        axi.rlast     = 1'b0;
        axi.awready   = 1'b0;
        axi.wready    = 1'b0;
        axi.bvalid    = 1'b0;
        axi.bresp     = 2'b00;
    endtask

    // One load; slave holds arready low for ar_wait cycles and delays rvalid by r_wait cycles.
    // hold>0 keeps req_valid high for that many cycles after refresh.
    task automatic run_load(input logic [AW-1:0] addr, input logic [2:0] size,
                            input logic [DW-1:0] data, input logic [1:0] resp,
                            input int ar_wait, input int r_wait, input int hold);
        int  exp_ref, drop, busy_end, ar_hs;
        bit  r_done;
        logic exp_v;
        exp_ref  = 3 + ar_wait + r_wait;
        drop     = (hold == 0) ? 1 : exp_ref + hold + 1;
        busy_end = (exp_ref + 1 > drop) ? exp_ref + 1 : drop;
        ar_hs    = -1;
        r_done   = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || rdata !== exp_rdata) begin
            n_fail++;
            $display("FAIL load_start: busy=%b rdata=%h required busy=0 rdata=%h",
                     busy, rdata, exp_rdata);
        end
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = addr;
        req_size  = size;
        req_wdata = {$urandom, $urandom};
        req_wstrb = 8'($urandom);
        for (int c = 1; c <= busy_end; c++) begin
            @(negedge clk);
            req_valid = (c < drop);
            req_addr  = {$urandom, $urandom};
            req_size  = 3'($urandom);
            n_checks++;
            if (busy !== 1'b1) begin
                n_fail++;
                $display("FAIL load_busy: cycle %0d busy=%b required 1", c, busy);
            end
            exp_v = (c <= 1 + ar_wait);
            n_checks++;
            if (axi.arvalid !== exp_v || axi.awvalid !== 1'b0 || axi.wvalid !== 1'b0) begin
                n_fail++;
                $display("FAIL load_valids: cycle %0d arvalid=%b aw/w=%b%b required %b 00",
                         c, axi.arvalid, axi.awvalid, axi.wvalid, exp_v);
            end
            if (axi.arvalid) begin
                n_checks++;
                if (axi.araddr !== addr || axi.arsize !== size || axi.arlen !== 8'd0 ||
                    axi.arburst !== 2'b01) begin
                    n_fail++;
                    $display("FAIL load_ar_payload: cycle %0d addr=%h size=%0d len=%0d burst=%b required %h %0d 0 01",
                             c, axi.araddr, axi.arsize, axi.arlen, axi.arburst, addr, size);
                end
            end
            exp_v = (c == exp_ref);
            n_checks++;
            if (refresh !== exp_v) begin
                n_fail++;
                $display("FAIL load_refresh: cycle %0d refresh=%b required %b", c, refresh, exp_v);
            end
            if (refresh) begin
                n_checks++;
                if (rdata !== data || resp_err !== resp[1]) begin
                    n_fail++;
                    $display("FAIL load_data: rdata=%h err=%b required %h %b",
                             rdata, resp_err, data, resp[1]);
                end
            end
            axi.arready = axi.arvalid && (c >= 1 + ar_wait);
            if (axi.arready) ar_hs = c;
            axi.rvalid    = (ar_hs >= 0) && (c >= ar_hs + 1 + r_wait) && !r_done;
            axi.rdata_axi = axi.rvalid ? data : {$urandom, $urandom};
            axi.rresp     = resp;
            axi.rlast     = axi.rvalid;
            if (axi.rvalid && axi.rready) r_done = 1'b1;
        end
        slave_idle();
        exp_rdata = data;
        @(negedge clk);
    endtask

    // One store; aw/w ready delays are independent, bvalid follows both by b_wait cycles.
    task automatic run_store(input logic [AW-1:0] addr, input logic [2:0] size,
                             input logic [DW-1:0] wd, input logic [7:0] ws, input logic [1:0] resp,
                             input int aw_wait, input int w_wait, input int b_wait);
        int  awh, wh, both, exp_ref;
        bit  b_done;
        logic exp_aw, exp_w, exp_b, exp_r;
        awh     = 1 + aw_wait;
        wh      = 1 + w_wait;
        both    = (awh > wh) ? awh : wh;
        exp_ref = both + 2 + b_wait;
        b_done  = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || rdata !== exp_rdata) begin
            n_fail++;
            $display("FAIL store_start: busy=%b rdata=%h required busy=0 rdata=%h",
                     busy, rdata, exp_rdata);
        end
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = addr;
        req_size  = size;
        req_wdata = wd;
        req_wstrb = ws;
        for (int c = 1; c <= exp_ref + 1; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            req_addr  = {$urandom, $urandom};
            req_wdata = {$urandom, $urandom};
            req_wstrb = 8'($urandom);
            n_checks++;
            if (busy !== 1'b1) begin
                n_fail++;
                $display("FAIL store_busy: cycle %0d busy=%b required 1", c, busy);
            end
            exp_aw = (c <= awh);
            exp_w  = (c <= wh);
            exp_b  = (c > both) && (c <= both + 1 + b_wait);
            n_checks++;
            if (axi.awvalid !== exp_aw || axi.wvalid !== exp_w || axi.bready !== exp_b ||
                axi.arvalid !== 1'b0) begin
                n_fail++;
                $display("FAIL store_valids: cycle %0d aw=%b w=%b bready=%b ar=%b required %b %b %b 0",
                         c, axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, exp_aw, exp_w, exp_b);
            end
            if (axi.awvalid) begin
                n_checks++;
                if (axi.awaddr !== addr || axi.awsize !== size || axi.awlen !== 8'd0 ||
                    axi.awburst !== 2'b01) begin
                    n_fail++;
                    $display("FAIL store_aw_payload: cycle %0d addr=%h size=%0d required %h %0d",
                             c, axi.awaddr, axi.awsize, addr, size);
                end
            end
            if (axi.wvalid) begin
                n_checks++;
                if (axi.wdata !== wd || axi.wstrb !== ws || axi.wlast !== 1'b1) begin
                    n_fail++;
                    $display("FAIL store_w_payload: cycle %0d data=%h strb=%h last=%b required %h %h 1",
                             c, axi.wdata, axi.wstrb, axi.wlast, wd, ws);
                end
            end
            exp_r = (c == exp_ref);
            n_checks++;
            if (refresh !== exp_r) begin
                n_fail++;
                $display("FAIL store_refresh: cycle %0d refresh=%b required %b", c, refresh, exp_r);
            end
            if (refresh) begin
                n_checks++;
                if (resp_err !== resp[1] || rdata !== exp_rdata) begin
                    n_fail++;
                    $display("FAIL store_resp: err=%b rdata=%h required %b %h",
                             resp_err, rdata, resp[1], exp_rdata);
                end
            end
            axi.awready = axi.awvalid && (c >= awh);
            axi.wready  = axi.wvalid && (c >= wh);
            axi.bvalid  = (c >= both + 1 + b_wait) && !b_done;
            axi.bresp   = resp;
            if (axi.bvalid && axi.bready) b_done = 1'b1;
        end
        slave_idle();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        n_checks++;
        if ({axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready} !== 5'b0 ||
            {refresh, resp_err, busy} !== 3'b0 || rdata !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: valids=%b%b%b%b%b status=%b%b%b rdata=%h required all 0",
                     axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready,
                     refresh, resp_err, busy, rdata);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || refresh !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b refresh=%b required 0 0", busy, refresh);
        end
    endtask

    task automatic test_load_zero_wait();
        run_load(64'ha000_0048, 3'd3, 64'h1122334455667788, 2'b00, 0, 0, 0);
    endtask

    task automatic test_store_reorder();
        run_store(64'ha000_03f8, 3'd2, 64'h0000_0000_dead_beef, 8'h0f, 2'b00, 3, 1, 1);
    endtask

    task automatic test_backpressure();
        run_load(64'ha000_1000, 3'd3, {$urandom, $urandom}, 2'b00, 5, 3, 0);
    endtask

    task automatic test_held_request();
        run_load(64'ha000_2008, 3'd2, {$urandom, $urandom}, 2'b00, 0, 0, 10);
        run_load(64'ha000_2010, 3'd1, {$urandom, $urandom}, 2'b00, 1, 0, 0);
    endtask

    task automatic test_error();
        run_store({$urandom, $urandom}, 3'd3, {$urandom, $urandom}, 8'hff, 2'b10, 0, 0, 0);
        run_load({$urandom, $urandom}, 3'd3, {$urandom, $urandom}, 2'b11, 0, 1, 0);
        run_load({$urandom, $urandom}, 3'd0, {$urandom, $urandom}, 2'b00, 0, 0, 0);
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = {$urandom, $urandom};
        req_size  = 3'd3;
        @(negedge clk);
        req_valid   = 1'b0;
        axi.arready = 1'b1;
        @(negedge clk);
        axi.arready = 1'b0;
        n_checks++;
        if (axi.rready !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_in_r: rready=%b busy=%b required 1 1", axi.rready, busy);
        end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready} !== 5'b0 ||
            {refresh, resp_err, busy} !== 3'b0 || rdata !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_async: valids=%b%b%b%b%b status=%b%b%b rdata=%h required all 0",
                     axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready,
                     refresh, resp_err, busy, rdata);
        end
        exp_rdata = '0;
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_checks++;
            if (refresh !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_mid_quiet: refresh=%b busy=%b required 0 0", refresh, busy);
            end
        end
        run_load({$urandom, $urandom}, 3'd3, {$urandom, $urandom}, 2'b00, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                run_load({$urandom, $urandom}, 3'($urandom_range(0, 3)), {$urandom, $urandom},
                         2'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 0);
            end else begin
                run_store({$urandom, $urandom}, 3'($urandom_range(0, 3)), {$urandom, $urandom},
                          8'($urandom), 2'($urandom), $urandom_range(0, 3),
                          $urandom_range(0, 3), $urandom_range(0, 3));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        slave_idle();
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_size  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        test_reset();
        test_load_zero_wait();
        test_store_reorder();
        test_backpressure();
        test_held_request();
        test_error();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ysyx_2022040010_uncache_axi.md
# ysyx_2022040010_uncache_axi

Uncached-access AXI4 master engine. It sits between the data-side uncache tag logic and the AXI interconnect. It accepts one uncached load or store from the MEM stage and performs it as a single-beat AXI4 read or write. On completion it returns a one-cycle `refresh` pulse with read data, which is the completion event the uncache tag logic waits on before releasing its stall.

## Interface
- `ADDR_W`, 64, request/AXI address width
- `DATA_W`, 64, request/AXI data width; `DATA_W/8` strobe bits
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `req_valid`  in  1  uncached access request (uncache & dsram_e), level
- `req_we`  in  1  1 = store, 0 = load
- `req_addr`  in  ADDR_W  byte address
- `req_size`  in  3  AXI size encoding (0=1B … 3=8B)
- `req_wdata`  in  DATA_W  store data, already lane-aligned
- `req_wstrb`  in  DATA_W/8  store byte strobes
- `refresh`  out  1  one-cycle completion pulse
- `rdata`  out  DATA_W  captured read data, valid with `refresh` and held until next capture
- `resp_err`  out  1  RESP[1] of the completing response, valid with `refresh`
- `busy`  out  1  high in any state other than IDLE
- `araddr`/`arsize`/`arlen`/`arburst`/`arvalid`  out  ADDR_W/3/8/2/1;  `arready`  in  1
- `rdata_axi`/`rresp`/`rlast`/`rvalid`  in  DATA_W/2/1/1;  `rready`  out  1
- `awaddr`/`awsize`/`awlen`/`awburst`/`awvalid`  out  ADDR_W/3/8/2/1;  `awready`  in  1
- `wdata`/`wstrb`/`wlast`/`wvalid`  out  DATA_W/DATA_W/8/1/1;  `wready`  in  1
- `bresp`/`bvalid`  in  2/1;  `bready`  out  1

## Operation
- States: IDLE, AR, R, AW_W, B, DONE, WAIT_LOW.
- IDLE: on `req_valid`, latch we/addr/size/wdata/wstrb. Go to AR if load, AW_W if store. Request inputs are ignored in every other state.
- AR: `arvalid`=1 with latched addr/size, `arlen`=0, `arburst`=2'b01. On `arvalid & arready`, go to R.
- R: `rready`=1. On `rvalid`, capture `rdata_axi` into `rdata`, capture `rresp[1]` into `resp_err`, and go to DONE. `rlast` is not checked, since `arlen`=0.
- AW_W: `awvalid` and `wvalid` are both asserted on entry, with `wlast`=1 and `awlen`=0.
  - Each handshake is tracked by its own done flag. Each valid drops the cycle after its own handshake.
  - Handshakes may occur in either order or in the same cycle.
  - When both are done, go to B.
- B: `bready`=1. On `bvalid`, capture `bresp[1]` into `resp_err` and go to DONE. `rdata` is unchanged.
- DONE: `refresh`=1 for exactly this one cycle. Then go to WAIT_LOW.
- WAIT_LOW: wait until `req_valid`=0, then go to IDLE. This prevents re-issuing the same access while the requester still drives its request.
  - If `req_valid` is already 0 in the DONE cycle, WAIT_LOW lasts one cycle.
- All AXI outputs are driven from registers. No combinational path from AXI inputs to AXI outputs.
- An error response still completes normally (`refresh` pulses). Error handling is the requester's responsibility.

## Timing
- Reset (async, `rst`=0): state IDLE. The following outputs are 0 immediately, without waiting for a clock edge:
  - valid/ready: `arvalid`, `awvalid`, `wvalid`, `rready`, `bready`
  - status: `refresh`, `resp_err`, `busy`
  - data: `rdata`
- Reset mid-transaction abandons the access. No `refresh` is produced. The interconnect must be reset together with this block.
- Load minimum latency, counted from the edge that samples `req_valid` as cycle 0:
  - cycle 1: `arvalid` (`arready` returned here)
  - cycle 2: `rvalid`
  - cycle 3: `refresh`
- Store minimum latency, counted from cycle 0 likewise:
  - cycle 1: `awvalid` and `wvalid` (both accepted here)
  - cycle 2: `bvalid`
  - cycle 3: `refresh`
- `arvalid`/`awvalid`/`wvalid` and their payloads stay stable until handshake, per AXI rules.
- Back-to-back accesses: a new request is accepted no earlier than 2 cycles after `refresh`, and only if `req_valid` has been low for at least one sampled cycle.

## Test plan
- Load, zero-wait slave: addr 0xa000_0048, size 3; slave returns 0x1122334455667788 OKAY.
  -> `arvalid` in cycle 1; `refresh` in cycle 3 with `rdata`=0x1122334455667788 and `resp_err`=0.
- Store with reordered channels: addr 0xa000_03f8, wstrb 0x0f, wdata 0xdeadbeef.
  - Slave: `wready` at cycle 2, `awready` at cycle 4, `bvalid` at cycle 6.
  - -> `wvalid` drops after cycle 2, `awvalid` drops after cycle 4, `refresh` at cycle 7, `rdata` unchanged.
- Backpressure: `arready` held low 5 cycles, then `rvalid` delayed 3 cycles.
  -> `araddr`/`arvalid` stable throughout; exactly one `refresh`; `busy` high from cycle 1 until the `refresh` cycle.
- Held request: `req_valid` kept high for 10 cycles past `refresh`.
  -> no second AR issued; a new load is accepted only after `req_valid` goes low for 1 cycle and rises again.
- Error and reset:
  - SLVERR `bresp`=2'b10 -> `refresh` with `resp_err`=1.
  - Separate run: `rst` pulled low while in R -> all outputs 0 immediately, state IDLE, no `refresh`; a subsequent load completes normally.
